button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 1000000, is the number of consecutive cycles the input must hold one level before a level change is accepted (20 ms at 50 MHz).
REQ-002 Parameter HOLD_CYCLES, default 50000000, is the number of cycles in the debounced-pressed state before a long-press pulse fires (1 s).
REQ-003 clk  input  1  system clock; one clock domain only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 button_n  input  1  raw push-button pin, active-low, asynchronous to clk and bouncing.
REQ-006 pressed  output  1  debounced level: 1 while the button is held.
REQ-007 press  output  1  one-cycle pulse on an accepted press.
REQ-008 release  output  1  one-cycle pulse on an accepted release.
REQ-009 long_press  output  1  one-cycle pulse when a press has lasted HOLD_CYCLES.
REQ-010 press_count  output  8  number of accepted presses, modulo 256.

Function
REQ-011 button_n SHALL pass through a 2-flop synchronizer; the FSM samples only the second flop. Define "raw_pressed" as the inverse of that flop.
REQ-012 The FSM SHALL have four states: RELEASED, WAIT_PRESS, PRESSED and WAIT_RELEASE.
REQ-013 RELEASED transitions to WAIT_PRESS when raw_pressed=1. Entry into WAIT_PRESS clears the debounce counter.
REQ-014 In WAIT_PRESS, each cycle with raw_pressed=1 increments the counter. When the counter equals STABLE_CYCLES-1 and raw_pressed=1, the FSM moves to PRESSED. If raw_pressed=0 on any cycle, the FSM returns to RELEASED with no pulse.
REQ-015 PRESSED and WAIT_RELEASE SHALL behave symmetrically for raw_pressed=0. A bounce in WAIT_RELEASE returns the FSM to PRESSED with no pulse.
REQ-016 All outputs SHALL be registered. press is high for exactly the one cycle after the FSM enters PRESSED from WAIT_PRESS; release follows the same rule for entry into RELEASED from WAIT_RELEASE.
REQ-017 Latency: with button_n held low from the first sampling edge E, press is high during the cycle after edge E+STABLE_CYCLES+2. Release latency is identical.
REQ-018 pressed SHALL be 1 in PRESSED and WAIT_RELEASE, and 0 otherwise.
REQ-019 press_count SHALL increment in the same cycle that press is asserted, wrapping from 255 to 0.
REQ-020 The hold counter SHALL clear on entry to PRESSED from WAIT_PRESS and increment only while in PRESSED. It keeps its value across a WAIT_RELEASE bounce back to PRESSED.
REQ-021 When the hold counter reaches HOLD_CYCLES, long_press SHALL pulse once. The counter then saturates, giving at most one long_press per press.
REQ-022 Counter widths SHALL be clog2 of the largest terminal value plus one. No counter may overflow for any legal parameter value.
REQ-023 STABLE_CYCLES >= 1 and HOLD_CYCLES >= 1 are legal. STABLE_CYCLES=1 accepts a level after a single cycle of agreement.
REQ-024 press and release SHALL never be asserted in the same cycle. long_press SHALL never be asserted in the same cycle as release.

Reset
REQ-025 While rst=1, the following SHALL take effect on the next clk edge:
- synchronizer flops are set to 1 (button released);
- FSM goes to RELEASED;
- all counters clear to 0;
- pressed, press, release, long_press = 0;
- press_count = 0.
REQ-026 Reset asserted mid-debounce or mid-hold SHALL abandon the operation with no pulse. After rst falls with the button held, a full new press sequence (REQ-017) is required.

Structure
REQ-027 A shared package/header SHALL hold the FSM state encoding and the default STABLE_CYCLES and HOLD_CYCLES constants.
REQ-028 The synchronizer SHALL be a separate sub-module, sync_2ff: 1 bit wide, with a reset value parameter. All other logic stays in button_debounce.

Verification
All scenarios use STABLE_CYCLES=4 and HOLD_CYCLES=10.
REQ-029 Clean press: button_n goes low at edge 0 and is held → press is high only in the cycle after edge 6; pressed=1 from then on; press_count=1.
REQ-030 Bounce: button_n goes low for 3 cycles, high for 1, then low and held → exactly one press, occurring 6 cycles after the final falling sample; press_count=1.
REQ-031 Long press: button held 20 cycles after press → exactly one long_press, 10 cycles after press; no second pulse.
REQ-032 Release with bounce: button_n goes high for 2 cycles, low for 1, then high and held → no release for the first glitch; exactly one release 6 cycles after the final rising sample; pressed=0.
REQ-033 Reset mid-hold: rst pulsed for 1 cycle while pressed → all outputs 0 and press_count=0 next cycle; with the button still low, a new press fires 6 cycles after rst falls.
REQ-034 Wrap: 256 clean presses → press_count returns to 0; 256 press pulses observed.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
// Holds the FSM state encoding and default timing constants.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } db_state_t;

  // 20 ms and 1 s at 50 MHz
  localparam int unsigned DEF_STABLE_CYCLES = 1000000;
  localparam int unsigned DEF_HOLD_CYCLES   = 50000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// RST_VAL sets the level both flops take under reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounces an active-low push button and reports press, release,
// long-press pulses and a running press count.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_n,
  output logic       pressed,
  output logic       press,
  output logic       release_pulse,
  output logic       long_press,
  output logic [7:0] press_count
);

  localparam int DW = $clog2(STABLE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_END = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);

  logic          btn_sync;
  logic          raw;
  db_state_t     state;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button_n),
    .q   (btn_sync)
  );

  assign raw = ~btn_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RELEASED;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      pressed       <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      press_count   <= '0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      unique case (state)
        RELEASED: begin
          if (raw) begin
            state  <= WAIT_PRESS;
            db_cnt <= '0;
          end
        end
        WAIT_PRESS: begin
          if (!raw) begin
            state <= RELEASED;
          end else if (db_cnt == DB_LAST) begin
            state       <= PRESSED;
            pressed     <= 1'b1;
            press       <= 1'b1;
            press_count <= press_count + 8'd1;
            hold_cnt    <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        PRESSED: begin
          // saturates at HOLD_END so long_press fires once per press
          if (hold_cnt != HOLD_END) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HOLD_PRE) long_press <= 1'b1;
          end
          if (!raw) begin
            state  <= WAIT_RELEASE;
            db_cnt <= '0;
          end
        end
        WAIT_RELEASE: begin
          if (raw) begin
            state <= PRESSED;
          end else if (db_cnt == DB_LAST) begin
            state         <= RELEASED;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed scenarios plus
// random bouncing, compared against a run-length reference model.
module tb_button_debounce;

  localparam int S = 4;
  localparam int H = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button_n = 1'b1;
  logic       pressed;
  logic       press;
  logic       release_pulse;
  logic       long_press;
  logic [7:0] press_count;

  button_debounce #(
    .STABLE_CYCLES (S),
    .HOLD_CYCLES   (H)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button_n      (button_n),
    .pressed       (pressed),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .press_count   (press_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic       m_s1 = 1'b1;
  logic       m_s2 = 1'b1;
  logic       m_level = 1'b0;
  int         m_run = 0;
  int         m_hold = 0;
  logic       m_press = 1'b0;
  logic       m_rel = 1'b0;
  logic       m_long = 1'b0;
  logic [7:0] m_cnt = 8'd0;

  int idx;
  int press_seen, rel_seen, long_seen;
  int first_press, first_rel, first_long;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Level flips once the synchronized input has disagreed with it
  // for S+1 consecutive samples; hold time counts settled-pressed cycles.
  task automatic model_edge(input logic bn, input logic r);
    logic raw;
    bit   settled;
    if (r) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0;
      m_run = 0; m_hold = 0; m_cnt = 8'd0;
      m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
    end else begin
      raw = ~m_s2;
      m_s2 = m_s1;
      m_s1 = bn;
      m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
      settled = m_level && (m_run == 0);
      if (settled && m_hold < H) begin
        m_hold++;
        if (m_hold == H) m_long = 1'b1;
      end
      if (raw != m_level) m_run++;
      else m_run = 0;
      if (m_run == S + 1) begin
        m_level = raw;
        m_run = 0;
        if (raw) begin
          m_press = 1'b1;
          m_cnt = m_cnt + 8'd1;
          m_hold = 0;
        end else begin
          m_rel = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic bn, input logic r);
    @(negedge clk);
    button_n = bn;
    rst = r;
    @(posedge clk);
    model_edge(bn, r);
    #1;
    check("outputs",
          {20'd0, pressed, press, release_pulse, long_press, press_count},
          {20'd0, m_level, m_press, m_rel, m_long, m_cnt});
    if (press) begin
      press_seen++;
      if (first_press < 0) first_press = idx;
    end
    if (release_pulse) begin
      rel_seen++;
      if (first_rel < 0) first_rel = idx;
    end
    if (long_press) begin
      long_seen++;
      if (first_long < 0) first_long = idx;
    end
    idx++;
  endtask

  task automatic clear_track();
    idx = 0;
    press_seen = 0; rel_seen = 0; long_seen = 0;
    first_press = -1; first_rel = -1; first_long = -1;
  endtask

  initial begin
    logic lvl;
    int   len;
    clear_track();

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    check("reset_state",
          {pressed, press, release_pulse, long_press, press_count}, 12'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);

    // clean press and long press
    clear_track();
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
    check("clean_press_idx", first_press, 6);
    check("clean_press_cnt", press_seen, 1);
    check("clean_pressed", pressed, 1);
    check("clean_count", press_count, 1);
    check("long_idx", first_long, 16);
    check("long_cnt", long_seen, 1);

    // release with a glitch
    clear_track();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
    check("rel_idx", first_rel, 9);
    check("rel_cnt", rel_seen, 1);
    check("rel_pressed", pressed, 0);
    check("rel_no_long", long_seen, 0);

    // press with a bounce
    clear_track();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
    check("bounce_idx", first_press, 10);
    check("bounce_cnt", press_seen, 1);
    check("bounce_count", press_count, 2);

    // reset while held
    clear_track();
    step(1'b0, 1'b1);
    check("rst_mid",
          {pressed, press, release_pulse, long_press, press_count}, 12'd0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
    check("rst_repress_idx", first_press, 7);
    check("rst_repress_count", press_count, 1);

    // wrap of press_count
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    clear_track();
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < S + 4; i++) step(1'b0, 1'b0);
      for (int i = 0; i < S + 4; i++) step(1'b1, 1'b0);
    end
    check("wrap_pulses", press_seen, 256);
    check("wrap_count", press_count, 0);

    // random bouncing with occasional reset
    lvl = 1'b1;
    for (int sgm = 0; sgm < 400; sgm++) begin
      len = $urandom_range(1, 9);
      lvl = ~lvl;
      for (int j = 0; j < len; j++)
        step(lvl, $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
